online_mult_seq: RTL
====================

# online_mult_seq

Sequencer for the radix-2 signed-digit online multiplier. It accepts two N-digit signed-digit operands in parallel and streams their digits MSD-first into `online_mult_1D`, then flushes the online delay with zero digits. It collects the N product digits into a parallel result register and reports completion through a start/busy/done handshake. It sits between a parallel-operand requester and one `online_mult_1D` instance, and owns that instance's `en` and clear.

## Interface
- `N`, 8: digits per operand and per result (N ≥ 2).
- `DELTA`, 3: online delay of the multiplier in cycles; first product digit appears after DELTA fed digits.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `abort` input 1: synchronous cancel; effective in CLR/RUN.
- `x_plus`, `x_minus` input N: operand X digits; bit N-1 is the MSD (weight 2^-1).
- `y_plus`, `y_minus` input N: operand Y digits, same format.
- `busy` output 1: high in CLR and RUN.
- `done` output 1: one-cycle pulse on completion.
- `z_plus`, `z_minus` output N: product digits; bit N-1 is the MSD. Held until the next accepted start.
- `mult_en` output 1: multiplier enable.
- `mult_clr` output 1: one-cycle synchronous clear to the multiplier's residual and digit registers.
- `mult_x`, `mult_y` output 2: digit to the multiplier, as {plus, minus}.
- `mult_z` input 2: digit from the multiplier, as {plus, minus}.

## Operation
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - On `start`=1, latch all four operand vectors into internal registers and go to CLR.
  - Any digit with plus=minus=1 is latched as 00.
- CLR:
  - Drive `mult_clr`=1 and `mult_en`=0 for exactly one cycle.
  - Clear the counter `k` to 0 and clear `z_plus` and `z_minus`.
  - Go to RUN.
- RUN:
  - Drive `mult_en`=1 for N+DELTA cycles, k = 0..N+DELTA-1.
  - For k<N, drive `mult_x`/`mult_y` with operand digit index N-1-k.
  - For k≥N, drive 00 on both.
  - At the edge ending cycle k with k≥DELTA, capture `mult_z` into result digit index N-1-(k-DELTA). A captured 11 is stored as 00.
  - After cycle N+DELTA-1, go to DONE.
- DONE:
  - `done`=1 for one cycle, then return to IDLE.
  - `start` is ignored in DONE.
- `start` is ignored while `busy`; no queuing.
- `abort`=1 in CLR or RUN:
  - Next state is IDLE.
  - `done` is not pulsed.
  - The result register keeps its partially written contents, and is not valid.
  - `abort` in IDLE or DONE has no effect.
- When `start` and `abort` are both high in IDLE, start wins.
- The counter is ⌈log2(N+DELTA)⌉ bits wide and does not wrap inside a transaction.
- Result value: Σ z_i·2^-(N-i) must satisfy |value(z) − value(x)·value(y)| < 2^-N.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `mult_en`=0, `mult_clr`=0.
  - `mult_x`=`mult_y`=00.
  - `z_plus`=`z_minus`=0.
  - Internal operand registers and counter are 0.
- Latency from the `start` sample edge:
  - 1 CLR cycle, then N+DELTA RUN cycles.
  - `done` is high in cycle N+DELTA+2 counted from the sample edge.
  - With N=8, DELTA=3, `done` rises 12 edges after start.
- Throughput: one operation per N+DELTA+3 cycles (IDLE, CLR, RUN, DONE). A new `start` is accepted the cycle after `done`.
- All outputs are registered or pure state decodes; `mult_x`/`mult_y` are stable for the whole RUN cycle.
- `rst_n` asserted mid-operation: all outputs return to reset values immediately, asynchronously.
- The multiplier's own `rst_n` is the same reset net. Its per-operation clear comes only via `mult_clr`.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → all outputs at reset values. Release → IDLE, and no `busy` until `start` is sampled.
- Basic product, N=4, DELTA=3: X digits MSD→LSD = 1,0,1,0 (0.625), Y = 1,0,0,0 (0.5).
  - `busy` high for 8 cycles.
  - `mult_en` high for 7 cycles.
  - `done` pulses once.
  - value(z) = 0.3125 ± <2^-4.
- Negative digits, N=8: X = 1,0,0,-1,1,0,-1,1 and Y = 1,0,1,-1,0,1,1,0 (the earlier bench digit stream) → value(z) within 2^-8 of the exact product; `mult_x` sequence on the wire matches X MSD-first, followed by 3 zero digits.
- Invalid digit: X MSD latched as plus=minus=1 → `mult_x`=00 at k=0. The result equals the product with that digit treated as 0.
- Back-to-back: `start` held high continuously → second operation begins the cycle after `done`; `start` pulses during `busy` are ignored (exactly two `done` pulses in 2·(N+DELTA+3) cycles).
- Abort: assert `abort` at RUN k=2 →
  - IDLE next cycle.
  - `mult_en`=0.
  - No `done`.
  - A following `start` produces a correct product, proving `mult_clr` clears the multiplier's leftover residual.

Source files
------------

// File: rtl/online_mult_seq.sv
// Sequencer for a radix-2 signed-digit online multiplier: streams two parallel
// operands MSD-first, flushes the online delay and gathers the product digits.
module online_mult_seq #(
    parameter int N     = 8,
    parameter int DELTA = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] x_plus,
    input  logic [N-1:0] x_minus,
    input  logic [N-1:0] y_plus,
    input  logic [N-1:0] y_minus,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] z_plus,
    output logic [N-1:0] z_minus,
    output logic         mult_en,
    output logic         mult_clr,
    output logic [1:0]   mult_x,
    output logic [1:0]   mult_y,
    input  logic [1:0]   mult_z
);

    localparam int KW = $clog2(N + DELTA);
    localparam logic [KW-1:0] K_DELTA = KW'(DELTA);
    localparam logic [KW-1:0] K_LAST  = KW'(N + DELTA - 1);
    localparam logic [N-1:0]  Z_MSB   = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0]  xp_q, xp_d, xm_q, xm_d;
    logic [N-1:0]  yp_q, yp_d, ym_q, ym_d;
    logic [N-1:0]  zp_q, zp_d, zm_q, zm_d;
    logic [1:0]    zdig;
    logic [N-1:0]  zmask;

    // The redundant encoding 11 carries no value; fold it to zero.
    function automatic logic [1:0] sd_clean(input logic [1:0] d);
        return (d == 2'b11) ? 2'b00 : d;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        xp_d    = xp_q;
        xm_d    = xm_q;
        yp_d    = yp_q;
        ym_d    = ym_q;
        zp_d    = zp_q;
        zm_d    = zm_q;
        zdig    = sd_clean(mult_z);
        zmask   = Z_MSB >> (k_q - K_DELTA);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xp_d    = x_plus & ~x_minus;
                    xm_d    = x_minus & ~x_plus;
                    yp_d    = y_plus & ~y_minus;
                    ym_d    = y_minus & ~y_plus;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                k_d     = '0;
                zp_d    = '0;
                zm_d    = '0;
                state_d = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                // Operands shift out MSD-first; zeros fill in to flush the delay.
                xp_d = {xp_q[N-2:0], 1'b0};
                xm_d = {xm_q[N-2:0], 1'b0};
                yp_d = {yp_q[N-2:0], 1'b0};
                ym_d = {ym_q[N-2:0], 1'b0};
                if (k_q >= K_DELTA) begin
                    zp_d = (zp_q & ~zmask) | (zmask & {N{zdig[1]}});
                    zm_d = (zm_q & ~zmask) | (zmask & {N{zdig[0]}});
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            xp_q    <= '0;
            xm_q    <= '0;
            yp_q    <= '0;
            ym_q    <= '0;
            zp_q    <= '0;
            zm_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            xp_q    <= xp_d;
            xm_q    <= xm_d;
            yp_q    <= yp_d;
            ym_q    <= ym_d;
            zp_q    <= zp_d;
            zm_q    <= zm_d;
        end
    end

    assign busy     = (state_q == S_CLR) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign mult_en  = (state_q == S_RUN);
    assign mult_clr = (state_q == S_CLR);
    assign mult_x   = (state_q == S_RUN) ? {xp_q[N-1], xm_q[N-1]} : 2'b00;
    assign mult_y   = (state_q == S_RUN) ? {yp_q[N-1], ym_q[N-1]} : 2'b00;
    assign z_plus   = zp_q;
    assign z_minus  = zm_q;

endmodule
